// File: rtl/proc_run_ctrl.sv
// Run/step/breakpoint controller gating a processor clock enable from a run switch and a debounced step button.
// Optional breakpoint logic and BREAK state are built only when PROC_RUN_CTRL_BKPT_EN is defined.
module proc_run_ctrl #(
    parameter int REG_WIDTH       = 32,
    parameter int CNT_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic [REG_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0] bkpt_addr,
    input  logic                 bkpt_valid,
    output logic                 cpu_en,
    output logic [1:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] exec_cnt
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    logic           run_s1_q, run_s2_q;
    logic           btn_s1_q, btn_s2_q;
    logic           btn_lvl_q, btn_lvl_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           step_pulse;
    state_t         state_q, state_d;
    logic           first_q, first_d;
    logic [CNT_WIDTH-1:0] exec_cnt_q;
    logic           hit;
    logic           hit_run;
    logic           cpu_en_raw;

    // A level is accepted once it has differed from the accepted level for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        btn_lvl_d  = btn_lvl_q;
        db_cnt_d   = '0;
        step_pulse = 1'b0;
        if (btn_s2_q != btn_lvl_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_lvl_d  = btn_s2_q;
                step_pulse = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

`ifdef PROC_RUN_CTRL_BKPT_EN
    assign hit = bkpt_valid && (pc == bkpt_addr);
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{pc, bkpt_addr, bkpt_valid};
    assign hit         = 1'b0;
`endif

    // Resuming from HALT must execute the instruction even if it sits on the breakpoint.
    assign hit_run = hit && !first_q;

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        cpu_en_raw = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_s2_q) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                cpu_en_raw = !hit_run;
                if (!run_s2_q) begin
                    state_d = ST_HALT;
                end else if (hit_run) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                cpu_en_raw = 1'b1;
                state_d    = ST_HALT;
            end
            ST_BREAK: begin
                if (!run_s2_q) begin
                    state_d = ST_HALT;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_lvl_q  <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= ST_HALT;
            first_q    <= 1'b0;
            exec_cnt_q <= '0;
        end else begin
            run_s1_q  <= run_sw;
            run_s2_q  <= run_s1_q;
            btn_s1_q  <= step_btn;
            btn_s2_q  <= btn_s1_q;
            btn_lvl_q <= btn_lvl_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            first_q   <= first_d;
            if (cpu_en) begin
                exec_cnt_q <= exec_cnt_q + 1'b1;
            end
        end
    end

    // Outputs are forced to the halted view while reset is held, before the first reset edge lands.
    assign cpu_en   = rstn && cpu_en_raw;
    assign state    = rstn ? state_q : ST_HALT;
    assign halted   = (state == ST_HALT) || (state == ST_BREAK);
    assign exec_cnt = exec_cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with a small pc model that advances by 4 on every enabled cycle.
module tb_proc_run_ctrl;

    logic        clk;
    logic        rstn;
    logic        run_sw;
    logic        step_btn;
    logic [31:0] pc;
    logic [31:0] bkpt_addr;
    logic        bkpt_valid;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [3:0]  exec_cnt;

    logic        pc_ld;
    logic [31:0] pc_ld_val;
    int          n_chk;
    int          n_pass;
    int          steps;

    proc_run_ctrl #(
        .REG_WIDTH      (32),
        .CNT_WIDTH      (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .pc        (pc),
        .bkpt_addr (bkpt_addr),
        .bkpt_valid(bkpt_valid),
        .cpu_en    (cpu_en),
        .state     (state),
        .halted    (halted),
        .exec_cnt  (exec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_ld) begin
            pc <= pc_ld_val;
        end else if (cpu_en) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (state === 2'b10) steps++;
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (state !== s && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, {30'd0, state}, {30'd0, s});
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_ld     = 1'b1;
        pc_ld_val = v;
        tick();
        pc_ld     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        steps      = 0;
        rstn       = 1'b0;
        run_sw     = 1'b1;
        step_btn   = 1'b0;
        bkpt_addr  = 32'd0;
        bkpt_valid = 1'b0;
        pc_ld      = 1'b1;
        pc_ld_val  = 32'd0;
        tick();
        tick();
        pc_ld = 1'b0;

        // reset held with run switch on
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd1);
        check("rst_cnt", {28'd0, exec_cnt}, 32'd0);
        rstn = 1'b1;
        tick();
        tick();
        check("sync_still_halt", {30'd0, state}, 32'd0);
        tick();
        check("run_after_3", {30'd0, state}, 32'd1);
        check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        tick();
        check("run_cnt1", {28'd0, exec_cnt}, 32'd1);

        // reset asserted mid-RUN
        rstn = 1'b0;
        #1;
        check("midrun_rst_state", {30'd0, state}, 32'd0);
        check("midrun_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("midrun_rst_cnt", {28'd0, exec_cnt}, 32'd0);
        run_sw = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("idle_halt", {30'd0, state}, 32'd0);

        // bouncing button: only the final stable press yields one step
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            step_btn = (i % 2 == 0);
            repeat (3) tick();
        end
        step_btn = 1'b1;
        repeat (20) tick();
        check("db_one_step", steps, 32'd1);
        check("db_cnt", {28'd0, exec_cnt}, 32'd1);
        check("db_back_halt", {30'd0, state}, 32'd0);
        step_btn = 1'b0;
        repeat (20) tick();
        check("db_release_halt", {30'd0, state}, 32'd0);

        // run switch and step pulse land in the same HALT cycle
        steps    = 0;
        step_btn = 1'b1;
        repeat (15) tick();
        run_sw = 1'b1;
        repeat (2) tick();
        check("sim_pre_halt", {30'd0, state}, 32'd0);
        tick();
        check("sim_run_wins", {30'd0, state}, 32'd1);
        repeat (3) tick();
        check("sim_no_step", steps, 32'd0);
        step_btn = 1'b0;

        // run switch off coinciding with a breakpoint hit
        bkpt_valid = 1'b1;
        bkpt_addr  = pc + 32'd8;
        run_sw     = 1'b0;
        tick();
        tick();
        check("coinc_pc", pc, bkpt_addr);
        check("coinc_state_run", {30'd0, state}, 32'd1);
`ifdef PROC_RUN_CTRL_BKPT_EN
        check("coinc_cpu_en", {31'd0, cpu_en}, 32'd0);
`else
        check("coinc_cpu_en", {31'd0, cpu_en}, 32'd1);
`endif
        tick();
        check("coinc_halt", {30'd0, state}, 32'd0);
        bkpt_valid = 1'b0;

        // breakpoint at 0x10 from a fresh reset
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        load_pc(32'd0);
        bkpt_addr  = 32'h10;
        bkpt_valid = 1'b1;
        run_sw     = 1'b1;
        wait_state(2'b01, 10, "bk_enter_run");
        for (int n = 0; n < 20 && pc != 32'h10; n++) tick();
        check("bk_reach_pc", pc, 32'h10);
        check("bk_cnt4", {28'd0, exec_cnt}, 32'd4);
`ifdef PROC_RUN_CTRL_BKPT_EN
        check("bk_cpu_en_off", {31'd0, cpu_en}, 32'd0);
        tick();
        check("bk_state_break", {30'd0, state}, 32'd3);
        check("bk_halted", {31'd0, halted}, 32'd1);
        check("bk_cnt_hold", {28'd0, exec_cnt}, 32'd4);
        check("bk_pc_hold", pc, 32'h10);

        // step out of BREAK, then resume run at the breakpoint address
        step_btn = 1'b1;
        wait_state(2'b10, 30, "bk_step");
        check("bk_step_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("bk_step_pc", pc, 32'h10);
        tick();
        check("bk_step_halt", {30'd0, state}, 32'd0);
        check("bk_step_cnt5", {28'd0, exec_cnt}, 32'd5);
        check("bk_step_pc14", pc, 32'h14);
        tick();
        check("bk_rerun", {30'd0, state}, 32'd1);
        check("bk_rerun_cpu_en", {31'd0, cpu_en}, 32'd1);
        step_btn = 1'b0;
        run_sw   = 1'b0;
        wait_state(2'b00, 10, "bk_stop_halt");
        load_pc(32'h10);
        run_sw = 1'b1;
        wait_state(2'b01, 10, "resume_run");
        check("resume_pc", pc, 32'h10);
        check("resume_not_suppressed", {31'd0, cpu_en}, 32'd1);
        tick();
        check("resume_stay_run", {30'd0, state}, 32'd1);
        check("resume_pc14", pc, 32'h14);
`else
        check("nobk_cpu_en_on", {31'd0, cpu_en}, 32'd1);
        tick();
        check("nobk_stay_run", {30'd0, state}, 32'd1);
        check("nobk_pc14", pc, 32'h14);
`endif
        run_sw = 1'b0;
        wait_state(2'b00, 10, "bk_end_halt");

        // 4-bit counter wraps after 16 enabled cycles
        rstn       = 1'b0;
        bkpt_valid = 1'b0;
        run_sw     = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        wait_state(2'b01, 10, "wrap_run");
        repeat (16) tick();
        check("wrap_cnt0", {28'd0, exec_cnt}, 32'd0);
        tick();
        check("wrap_cnt1", {28'd0, exec_cnt}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
